// File: rtl/cond_unit.sv
// cond_unit: pipelined condition evaluator with a one-deep valid/ready output
// register, stored compare flags for compare-then-branch sequences, and a
// saturating count of true results.
module cond_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [7:0]       condition_i,
    input  logic [WIDTH-1:0] input1_i,
    input  logic [WIDTH-1:0] input2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             output_o,
    output logic             out_en_o,
    output logic             flag_err_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] true_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Condition code fields; bits [7:6] carry no meaning.
    logic       cond_en;
    logic       cond_flag_mode;
    logic       cond_signed;
    logic [2:0] cond_op;
    logic       cond_unused;

    assign cond_en        = condition_i[5];
    assign cond_flag_mode = condition_i[4];
    assign cond_signed    = condition_i[3];
    assign cond_op        = condition_i[2:0];
    assign cond_unused    = ^condition_i[7:6];

    // State registers
    logic             out_valid_q, out_valid_d;
    logic             output_q,    output_d;
    logic             out_en_q,    out_en_d;
    logic             flag_err_q,  flag_err_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             flag_eq_q,   flag_eq_d;
    logic             flag_ltu_q,  flag_ltu_d;
    logic             flag_lts_q,  flag_lts_d;
    logic             flags_ok_q,  flags_ok_d;

    // Datapath intermediates
    logic accept;
    logic cmp_eq, cmp_ltu, cmp_lts;
    logic sel_eq, sel_lt;
    logic op_result;
    logic result;
    logic no_flags_err;

    // A new transaction can enter whenever the output slot is empty or draining.
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    // Raw operand comparison, both unsigned and two's-complement.
    always_comb begin
        cmp_eq  = (input1_i == input2_i);
        cmp_ltu = (input1_i < input2_i);
        cmp_lts = ($signed(input1_i) < $signed(input2_i));
    end

    // Pick live or stored flags, then evaluate the selected operation.
    always_comb begin
        sel_eq = cond_flag_mode ? flag_eq_q : cmp_eq;
        if (cond_flag_mode) begin
            sel_lt = cond_signed ? flag_lts_q : flag_ltu_q;
        end else begin
            sel_lt = cond_signed ? cmp_lts : cmp_ltu;
        end
        case (cond_op)
            3'd0:    op_result = sel_eq;
            3'd1:    op_result = !sel_eq;
            3'd2:    op_result = sel_lt;
            3'd3:    op_result = sel_lt || sel_eq;
            3'd4:    op_result = !sel_lt && !sel_eq;
            3'd5:    op_result = !sel_lt;
            3'd6:    op_result = 1'b1;
            default: op_result = 1'b0;
        endcase
        // Flag mode with nothing stored yet forces a false, flagged result.
        no_flags_err = cond_en && cond_flag_mode && !flags_ok_q;
        result       = cond_en && !no_flags_err && op_result;
    end

    // Next-state: output slot, stored flags and saturating true counter.
    always_comb begin
        out_valid_d = out_valid_q;
        output_d    = output_q;
        out_en_d    = out_en_q;
        flag_err_d  = flag_err_q;
        flag_eq_d   = flag_eq_q;
        flag_ltu_d  = flag_ltu_q;
        flag_lts_d  = flag_lts_q;
        flags_ok_d  = flags_ok_q;
        cnt_d       = cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            output_d    = result;
            out_en_d    = cond_en;
            flag_err_d  = no_flags_err;
            if (cond_en && !cond_flag_mode) begin
                flag_eq_d  = cmp_eq;
                flag_ltu_d = cmp_ltu;
                flag_lts_d = cmp_lts;
                flags_ok_d = 1'b1;
            end
            if (result && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        // Clearing takes priority over a same-cycle increment.
        if (clr_cnt_i) begin
            cnt_d = '0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            output_q    <= 1'b0;
            out_en_q    <= 1'b0;
            flag_err_q  <= 1'b0;
            flag_eq_q   <= 1'b0;
            flag_ltu_q  <= 1'b0;
            flag_lts_q  <= 1'b0;
            flags_ok_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            output_q    <= output_d;
            out_en_q    <= out_en_d;
            flag_err_q  <= flag_err_d;
            flag_eq_q   <= flag_eq_d;
            flag_ltu_q  <= flag_ltu_d;
            flag_lts_q  <= flag_lts_d;
            flags_ok_q  <= flags_ok_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign output_o    = output_q;
    assign out_en_o    = out_en_q;
    assign flag_err_o  = flag_err_q;
    assign true_cnt_o  = cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: directed and randomized checks of cond_unit against a
// behavioural model built from the condition rules with plain integers.
module tb_cond_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready, in_ready2;
    logic [7:0]   condition;
    logic [W-1:0] input1, input2;
    logic         out_valid, out_valid2;
    logic         out_ready;
    logic         output_bit, output_bit2;
    logic         out_en, out_en2;
    logic         flag_err, flag_err2;
    logic         clr_cnt;
    logic [15:0]  true_cnt;
    logic [1:0]   true_cnt2;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_ov;
    bit m_r, m_en, m_err;
    bit m_eq, m_ltu, m_lts, m_ok;
    int m_cnt;

    cond_unit #(.WIDTH(W), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .condition_i(condition), .input1_i(input1), .input2_i(input2),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .output_o(output_bit),
        .out_en_o(out_en), .flag_err_o(flag_err), .clr_cnt_i(clr_cnt),
        .true_cnt_o(true_cnt)
    );

    cond_unit #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .condition_i(condition), .input1_i(input1), .input2_i(input2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready), .output_o(output_bit2),
        .out_en_o(out_en2), .flag_err_o(flag_err2), .clr_cnt_i(clr_cnt),
        .true_cnt_o(true_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit eval_op(input bit [2:0] op, input bit eq, input bit lt);
        case (op)
            3'd0: return eq;
            3'd1: return !eq;
            3'd2: return lt;
            3'd3: return lt || eq;
            3'd4: return !lt && !eq;
            3'd5: return !lt;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int to_signed(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    task automatic model_accept(input bit [7:0] c, input bit [W-1:0] a, input bit [W-1:0] b);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        if (!c[5]) begin
            m_r = 0; m_en = 0; m_err = 0;
        end else begin
            m_en = 1;
            if (c[4]) begin
                if (!m_ok) begin
                    m_r = 0; m_err = 1;
                end else begin
                    m_r = eval_op(c[2:0], m_eq, c[3] ? m_lts : m_ltu);
                    m_err = 0;
                end
            end else begin
                m_eq  = (ia == ib);
                m_ltu = (ia < ib);
                m_lts = (to_signed(ia) < to_signed(ib));
                m_ok  = 1;
                m_r   = eval_op(c[2:0], m_eq, c[3] ? m_lts : m_ltu);
                m_err = 0;
            end
        end
        if (m_r) m_cnt++;
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock cycle: drive at the falling edge, check after the rising edge.
    task automatic cycle(input bit iv, input bit [7:0] c, input bit [W-1:0] a,
                         input bit [W-1:0] b, input bit ordy, input bit clr);
        bit acc;
        @(negedge clk);
        in_valid = iv; condition = c; input1 = a; input2 = b;
        out_ready = ordy; clr_cnt = clr;
        #1;
        chk("in_ready", in_ready, !m_ov || ordy);
        acc = iv && (!m_ov || ordy);
        @(posedge clk);
        #1;
        if (acc) begin
            model_accept(c, a, b);
            m_ov = 1;
        end else if (ordy) begin
            m_ov = 0;
        end
        if (clr) m_cnt = 0;
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("output", output_bit, m_r);
            chk("out_en", out_en, m_en);
            chk("flag_err", flag_err, m_err);
        end
        chk("true_cnt", true_cnt, sat(m_cnt, 65535));
        chk("true_cnt_w2", true_cnt2, sat(m_cnt, 3));
        $display("txn t=%0t iv=%0d cond=%02h a=%02h b=%02h rdy=%0d clr=%0d acc=%0d -> ov=%0d out=%0d en=%0d err=%0d cnt=%0d cnt2=%0d",
                 $time, iv, c, a, b, ordy, clr, acc, out_valid, output_bit, out_en, flag_err, true_cnt, true_cnt2);
        in_valid = 0;
        clr_cnt  = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_output"}, output_bit, 0);
        chk({tag, "_out_en"}, out_en, 0);
        chk({tag, "_flag_err"}, flag_err, 0);
        chk({tag, "_true_cnt"}, true_cnt, 0);
        chk({tag, "_true_cnt_w2"}, true_cnt2, 0);
        chk({tag, "_out_valid_w2"}, out_valid2, 0);
    endtask

    task automatic model_reset();
        m_ov = 0; m_r = 0; m_en = 0; m_err = 0;
        m_eq = 0; m_ltu = 0; m_lts = 0; m_ok = 0; m_cnt = 0;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; condition = 0; input1 = 0; input2 = 0;
        out_ready = 1; clr_cnt = 0;
        model_reset();
        #1;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Flag mode with no stored flags, then plain equality.
        cycle(1, 8'h30, 8'h00, 8'h00, 1, 0);
        cycle(1, 8'h20, 8'h05, 8'h05, 1, 0);
        // Unsigned vs signed less-than on 0xFF / 0x01.
        cycle(1, 8'h22, 8'hFF, 8'h01, 1, 0);
        cycle(1, 8'h2A, 8'hFF, 8'h01, 1, 0);
        // Compare then flag-mode GT, back to back.
        cycle(1, 8'h22, 8'h03, 8'h07, 1, 0);
        cycle(1, 8'h34, 8'h00, 8'h00, 1, 0);
        // Signed flag-mode reads the stored signed flag.
        cycle(1, 8'h29, 8'h80, 8'h7F, 1, 0);
        cycle(1, 8'h3A, 8'h00, 8'h00, 1, 0);
        cycle(1, 8'h32, 8'h00, 8'h00, 1, 0);

        // Output stall: one accept, three blocked cycles, then release.
        cycle(1, 8'h23, 8'h09, 8'h09, 0, 0);
        repeat (3) cycle(1, 8'h24, 8'h01, 8'h02, 0, 0);
        cycle(1, 8'h24, 8'h01, 8'h02, 1, 0);
        cycle(0, 8'h00, 8'h00, 8'h00, 1, 0);

        // Disabled transaction, then clear and saturate the narrow counter.
        cycle(1, 8'h00, 8'h11, 8'h11, 1, 0);
        cycle(0, 8'h00, 8'h00, 8'h00, 1, 1);
        repeat (4) cycle(1, 8'h26, 8'h00, 8'h00, 1, 0);
        cycle(1, 8'hC6, 8'h00, 8'h00, 1, 0);
        cycle(1, 8'h27, 8'h00, 8'h00, 1, 0);

        // Reset while a result is stalled.
        cycle(1, 8'h26, 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        rst_n = 0;
        in_valid = 0;
        #1;
        model_reset();
        check_reset_state("midreset");
        chk("midreset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        cycle(1, 8'h30, 8'h00, 8'h00, 1, 0);
        cycle(1, 8'h26, 8'h00, 8'h00, 1, 0);
        cycle(1, 8'h26, 8'h00, 8'h00, 1, 1);

        // Randomized traffic with random back-pressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), W'($urandom_range(0, 3) == 0 ? 8'h40 : $urandom),
                  W'($urandom_range(0, 3) == 0 ? 8'h40 : $urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 31) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
